// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Normal op: busy for WIDTH+1 cycles, then a one-cycle done pulse; divide by zero finishes in 2 cycles.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

  // Top bit of the diff is the borrow: set means the trial subtract went negative, so restore.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge    = ~w_diff[WIDTH+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_qneg        <= 1'b0;
      r_rneg        <= 1'b0;
      r_dz          <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_busy <= 1'b1;
              r_dvs  <= w_dvs_mag;
              r_cnt  <= CW'(WIDTH - 1);
              if (divisor == '0) begin
                // Skip the iterations; FIX then emits all-ones and the raw dividend.
                r_state <= S_FIX;
                r_dz    <= 1'b1;
                r_quo   <= '1;
                r_rem   <= dividend;
                r_qneg  <= 1'b0;
                r_rneg  <= 1'b0;
              end else begin
                r_state <= S_CALC;
                r_dz    <= 1'b0;
                r_quo   <= w_dvd_mag;
                r_rem   <= '0;
                r_qneg  <= w_dvd_neg ^ w_dvs_neg;
                r_rneg  <= w_dvd_neg;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_CALC: begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - CW'(1);
          end
          S_FIX: begin
            r_quotient    <= r_qneg ? (~r_quo + 1'b1) : r_quo;
            r_remainder   <= r_rneg ? (~r_rem + 1'b1) : r_rem;
            r_div_by_zero <= r_dz;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against an arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] lq = '0;
  logic [31:0] lr = '0;
  logic        ldz = 1'b0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend's sign.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Starts an op in the current cycle and returns in its done cycle.
  task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic noise);
    int lat;
    int bad_busy;
    logic [31:0] eq, er;
    logic edz;
    model(sgn, a, b, eq, er, edz);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    step();
    start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
    lat = 1; bad_busy = 0;
    while (!done && lat < 200) begin
      if (!busy) bad_busy++;
      start = noise && lat >= 5 && lat <= 20;
      step();
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, (b == 32'd0) ? 32'd2 : 32'd34);
    chk({tag, "_busyrun"}, bad_busy, 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    lq = eq; lr = er; ldz = edz;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int dones;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) dones++;
      step();
    end
    chk({tag, "_nodone"}, dones, 32'd0);
    chk({tag, "_q_held"}, quotient, lq);
    chk({tag, "_r_held"}, remainder, lr);
    chk({tag, "_dz_held"}, {31'd0, div_by_zero}, {31'd0, ldz});
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    #9 rst = 1'b0;
    step();

    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    step();
    chk("single_done", {31'd0, done}, 32'd0);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    step();
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    step();
    do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    step();
    do_op("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    step();
    do_op("divu_5_9", 1'b0, 32'd5, 32'd9, 1'b0);
    step();
    do_op("div_by0", 1'b1, 32'h1234_5678, 32'd0, 1'b0);
    step();
    do_op("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0);
    step();

    // Flush mid-op at cycle 10.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    expect_quiet("flush", 40);

    // Flush and start together: start is dropped.
    start = 1'b1; flush = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flushstart_busy", {31'd0, busy}, 32'd0);
    expect_quiet("flushstart", 40);

    do_op("noise", 1'b1, 32'hFFFF_FF00, 32'd9, 1'b1);
    step();
    chk("noise_single", {31'd0, done}, 32'd0);
    step();

    // Back-to-back: second start in the first op's done cycle.
    do_op("b2b_a", 1'b0, 32'd1000, 32'd33, 1'b0);
    do_op("b2b_b", 1'b1, 32'hFFFF_F000, 32'd7, 1'b0);
    // Flush during a done cycle leaves the results and drops back to idle.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushdone_busy", {31'd0, busy}, 32'd0);
    expect_quiet("flushdone", 5);

    for (int i = 0; i < 40; i++) begin
      logic sgn;
      logic [31:0] a, b;
      int sel;
      sgn = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = 32'd0;
      else if (sel <= 2) b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 14))
                                                         : 32'($urandom_range(1, 15));
      else               b = $urandom;
      do_op($sformatf("rnd%0d", i), sgn, a, b, 1'($urandom_range(0, 3) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    // Async reset at cycle 20 of a running op.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd12345; divisor = 32'd11;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    lq = '0; lr = '0; ldz = 1'b0;
    step();
    expect_quiet("arst", 50);
    do_op("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider for the EX stage. Handles MIPS DIV/DIVU.
- Consumes the same forwarded operand pair that feeds the EX-stage bit-count and ALU logic.
- Produces quotient and remainder for the HI/LO write path.
- While busy, the pipeline-control logic uses its status to stall EX.

Parameters:
- WIDTH, 32, operand/result width. Latency formulas below are in terms of WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  launch a divide; accepted only when busy=0
- is_signed  in  1  1=DIV (two's complement), 0=DIVU; sampled with start
- dividend  in  WIDTH  numerator; sampled with start
- divisor  in  WIDTH  denominator; sampled with start
- flush  in  1  abort current operation (exception/branch flush)
- busy  out  1  operation in progress; EX stall request
- done  out  1  single-cycle pulse, results valid
- quotient  out  WIDTH  result to LO
- remainder  out  WIDTH  result to HI
- div_by_zero  out  1  flag for the last completed op; valid with done, held afterwards

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers 0.
- States:
  - IDLE: start & !flush -> CALC, or FIX if divisor==0.
  - CALC: runs exactly WIDTH cycles, counter WIDTH-1 down to 0. At count 0 -> FIX.
  - FIX: sign correction, 1 cycle -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE. start in DONE is accepted exactly as in IDLE.
- Accept at edge E0 (start sampled high at end of cycle 0):
  - Operands and is_signed are latched.
  - Signed mode converts operands to magnitudes. |0x80000000| = 2^31, which fits unsigned WIDTH.
  - Signs are recorded: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend).
- CALC iteration:
  - Shift the {partial remainder, dividend} pair left by 1.
  - Trial-subtract the divisor magnitude on a WIDTH+1-bit adder.
  - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
- FIX: negate the quotient if q_neg; negate the remainder if r_neg (signed mode only). Write quotient, remainder and div_by_zero output registers.
- Timing (normal): busy=1 in cycles 1..WIDTH+1; done=1 in cycle WIDTH+2 (34 for WIDTH=32); busy=0 in the done cycle. Results are valid from the done cycle and held until the next FIX.
- Divide by zero: IDLE -> FIX -> DONE. done in cycle 2; quotient = all ones; remainder = original dividend; div_by_zero=1. Other ops clear div_by_zero.
- Signed overflow 0x80000000 / -1: quotient=0x80000000, remainder=0, div_by_zero=0. This falls out of the algorithm, no special case.
- start while busy=1: ignored, with no effect on the operation in flight.
- flush:
  - In any state, next state is IDLE and busy=0 the next cycle.
  - No done pulse for the aborted op; quotient/remainder/div_by_zero keep their previous values.
- flush & start in the same cycle: flush wins and the start is dropped.
- flush in the DONE cycle: the done pulse in that cycle stands, since results were already written.
- Reset mid-operation: immediate return to reset values, no done.
- done never asserts twice for one accepted start. A new start may be accepted in the DONE cycle, giving back-to-back ops with no idle gap.

Test Plan:
- Unsigned: DIVU 100/7 at cycle 0 -> busy cycles 1..33; done cycle 34; q=14, r=2, dz=0.
- Signed: DIV 0xFFFFFFF9(-7) / 2 -> q=0xFFFFFFFD(-3), r=0xFFFFFFFF(-1). Also DIV 7/0xFFFFFFFE(-2) -> q=0xFFFFFFFD, r=1.
- Edge values:
  - DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
  - DIVU same operands -> q=0, r=0x80000000.
  - DIVU 5/9 -> q=0, r=5.
- Divide by zero: DIV 0x12345678/0 -> done cycle 2, q=0xFFFFFFFF, r=0x12345678, dz=1. A following DIVU 9/3 -> q=3, r=0, dz=0.
- Flush and ignored start:
  - Start 100/7, flush in cycle 10 -> busy=0 in cycle 11, no done, outputs retain prior values.
  - start asserted in cycles 5..20 of a running op -> ignored, single done at 34 with the original result.
- Back-to-back: second start asserted in the done cycle (34) -> accepted; second done in cycle 68. Async rst pulse in cycle 20 -> all outputs 0 immediately, no done thereafter.
